// File: rtl/crossing_arb_pkg.sv
// crossing_arb_pkg: shared types and defaults for the crossing-block arbiter.
package crossing_arb_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int ID_MAX_W = 3;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [WIDTH_DEF-1:0] pass;
        logic [WIDTH_DEF-1:0] sum;
        logic ovf;
    } result_t;
endpackage

// File: rtl/crossing_unit.sv
// crossing_unit: combinational shared adder, o1 = i1, o2 = i1 + i2.
// Saturating sum when CROSSING_ARB_SAT_EN is defined, wrap-around otherwise.
module crossing_unit import crossing_arb_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic ovf
);
    logic [WIDTH:0] s;
    assign s = {1'b0, i1} + {1'b0, i2};
    assign o1 = i1;
    assign ovf = s[WIDTH];
`ifdef CROSSING_ARB_SAT_EN
    assign o2 = s[WIDTH] ? '1 : s[WIDTH-1:0];
`else
    assign o2 = s[WIDTH-1:0];
`endif
endmodule

// File: rtl/crossing_block_arbiter.sv
// crossing_block_arbiter: round-robin arbiter sequencing requesters onto one shared adder.
// Sum saturation is selected in crossing_unit by CROSSING_ARB_SAT_EN.
module crossing_block_arbiter import crossing_arb_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic [N_REQ-1:0] io_req_valid,
    output logic [N_REQ-1:0] io_req_ready,
    input  logic [N_REQ*WIDTH-1:0] io_req_a,
    input  logic [N_REQ*WIDTH-1:0] io_req_b,
    output logic io_resp_valid,
    input  logic io_resp_ready,
    output logic [ID_W-1:0] io_resp_id,
    output logic [WIDTH-1:0] io_resp_pass,
    output logic [WIDTH-1:0] io_resp_sum,
    output logic io_resp_ovf,
    output logic io_busy
);
    state_t state;
    logic [ID_W-1:0] ptr, sel, op_id;
    logic [WIDTH-1:0] op_a, op_b, u_pass, u_sum;
    logic any, fire, u_ovf;
    // Rotated priority encoder: scan from the far end so the slot nearest ptr wins.
    always_comb begin
        int j;
        sel = '0;
        any = 1'b0;
        j = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            j = (j >= N_REQ) ? j - N_REQ : j;
            if (io_req_valid[j]) begin
                sel = ID_W'(j);
                any = 1'b1;
            end
        end
    end
    assign fire = reset_n && state == IDLE && any;
    assign io_req_ready = fire ? N_REQ'(1) << sel : '0;
    crossing_unit #(.WIDTH(WIDTH)) u_unit (
        .i1(op_a),
        .i2(op_b),
        .o1(u_pass),
        .o2(u_sum),
        .ovf(u_ovf)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr <= '0;
            op_a <= '0;
            op_b <= '0;
            op_id <= '0;
            io_resp_valid <= 1'b0;
            io_resp_id <= '0;
            io_resp_pass <= '0;
            io_resp_sum <= '0;
            io_resp_ovf <= 1'b0;
            io_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    op_a <= io_req_a[sel*WIDTH +: WIDTH];
                    op_b <= io_req_b[sel*WIDTH +: WIDTH];
                    op_id <= sel;
                    ptr <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
                    io_busy <= 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    io_resp_id <= op_id;
                    io_resp_pass <= u_pass;
                    io_resp_sum <= u_sum;
                    io_resp_ovf <= u_ovf;
                    io_resp_valid <= 1'b1;
                    state <= RESP;
                end
                default: if (io_resp_ready) begin
                    io_resp_valid <= 1'b0;
                    io_busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_crossing_block_arbiter.sv
// tb_crossing_block_arbiter: table vectors plus corner sequences, checked by a response scoreboard.
module tb_crossing_block_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] valid = '0;
    logic [N-1:0] ready;
    logic [N*W-1:0] a = '0, b = '0;
    logic resp_ready = 1'b1;
    logic resp_valid, resp_ovf, busy;
    logic [1:0] resp_id;
    logic [W-1:0] resp_pass, resp_sum;
    int errors = 0, checks = 0, cyc = 0, mptr = 0, mg;
    typedef struct {int id; logic [W-1:0] pass; logic [W-1:0] sum; logic ovf;} exp_t;
    typedef struct {int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] sw; logic [W-1:0] ss; logic ovf;} vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t tbl[8];

    crossing_block_arbiter dut (
        .clk(clk), .reset_n(reset_n), .io_req_valid(valid), .io_req_ready(ready),
        .io_req_a(a), .io_req_b(b), .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
        .io_resp_id(resp_id), .io_resp_pass(resp_pass), .io_resp_sum(resp_sum),
        .io_resp_ovf(resp_ovf), .io_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr(int p, logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic exp_t model(int id, logic [W-1:0] x, logic [W-1:0] y);
        exp_t r;
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        r.id = id;
        r.pass = x;
        r.ovf = s[W];
`ifdef CROSSING_ARB_SAT_EN
        r.sum = s[W] ? {W{1'b1}} : s[W-1:0];
`else
        r.sum = s[W-1:0];
`endif
        return r;
    endfunction

    // Grant checker and scoreboard: expectations pushed at each handshake, popped at each response.
    always @(negedge clk) if (reset_n) begin
        if (ready != '0) begin
            mg = rr(mptr, valid);
            check("grant_sel", ready, mg < 0 ? 32'd0 : 32'd1 << mg);
            if (mg >= 0) begin
                sb.push_back(model(mg, a[mg*W +: W], b[mg*W +: W]));
                mptr = (mg + 1) % N;
            end
        end
        if (resp_valid && resp_ready) begin
            if (sb.size() == 0) check("resp_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check("sb_id", resp_id, e.id);
                check("sb_pass", resp_pass, e.pass);
                check("sb_sum", resp_sum, e.sum);
                check("sb_ovf", resp_ovf, e.ovf);
            end
        end
    end

    task automatic set_ops(int k, logic [W-1:0] x, logic [W-1:0] y);
        a[k*W +: W] = x;
        b[k*W +: W] = y;
    endtask

    task automatic wait_grant(logic [N-1:0] exp_rdy);
        int n = 0;
        do @(negedge clk); while (ready == '0 && ++n < 20);
        check("grant_wait", ready, exp_rdy);
        @(posedge clk);
        #1 valid = '0;
    endtask

    task automatic do_req(int k, logic [W-1:0] x, logic [W-1:0] y);
        logic [N-1:0] m;
        m = '0;
        m[k] = 1'b1;
        set_ops(k, x, y);
        valid = m;
        wait_grant(m);
    endtask

    task automatic wait_resp();
        int n = 0;
        do @(negedge clk); while (!resp_valid && ++n < 20);
        if (!resp_valid) check("resp_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] s_exp;
        int idx, last;
        tbl = '{
            '{0, 8'h12, 8'h34, 8'h46, 8'h46, 1'b0},
            '{1, 8'hF0, 8'h20, 8'h10, 8'hFF, 1'b1},
            '{3, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b1},
            '{2, 8'h80, 8'h80, 8'h00, 8'hFF, 1'b1},
            '{0, 8'h7F, 8'h01, 8'h80, 8'h80, 1'b0},
            '{1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0},
            '{3, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 1'b1},
            '{2, 8'hA5, 8'h5A, 8'hFF, 8'hFF, 1'b0}
        };
        // Reset state, with requests pending to show ready stays low in reset.
        valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_id", resp_id, 0);
        check("rst_pass", resp_pass, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_ovf", resp_ovf, 0);
        check("rst_busy", busy, 0);
        valid = '0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // Single request from 2: response two cycles after the handshake cycle.
        set_ops(2, 8'h12, 8'h34);
        valid = 4'b0100;
        @(negedge clk);
        check("single_ready", ready, 4'b0100);
        @(posedge clk);
        #1 valid = '0;
        @(negedge clk);
        check("single_exec_valid", resp_valid, 0);
        check("single_exec_busy", busy, 1);
        @(negedge clk);
        check("single_valid", resp_valid, 1);
        check("single_id", resp_id, 2);
        check("single_pass", resp_pass, 8'h12);
        check("single_sum", resp_sum, 8'h46);
        check("single_ovf", resp_ovf, 0);
        @(negedge clk);
        check("single_idle_busy", busy, 0);
        check("single_idle_valid", resp_valid, 0);
        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 do_req(tbl[i].id, tbl[i].a, tbl[i].b);
            wait_resp();
`ifdef CROSSING_ARB_SAT_EN
            s_exp = tbl[i].ss;
`else
            s_exp = tbl[i].sw;
`endif
            check("tbl_id", resp_id, tbl[i].id);
            check("tbl_pass", resp_pass, tbl[i].a);
            check("tbl_sum", resp_sum, s_exp);
            check("tbl_ovf", resp_ovf, tbl[i].ovf);
        end
        // Backpressure: outputs frozen, no grants while the response waits.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        do_req(1, 8'h21, 8'h43);
        wait_resp();
        set_ops(0, 8'h55, 8'h66);
        valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 1);
            check("bp_ready", ready, 0);
            check("bp_id", resp_id, 1);
            check("bp_sum", resp_sum, 8'h64);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_busy", busy, 0);
        check("bp_release_valid", resp_valid, 0);
        // A valid dropped before grant is ignored; the later requester wins.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        do_req(2, 8'h01, 8'h02);
        wait_resp();
        @(posedge clk);
        #1 set_ops(1, 8'h77, 8'h11);
        valid = 4'b0010;
        @(posedge clk);
        #1 valid = '0;
        set_ops(3, 8'h30, 8'h03);
        valid = 4'b1000;
        resp_ready = 1'b1;
        wait_grant(4'b1000);
        wait_resp();
        check("drop_id", resp_id, 3);
        check("drop_sum", resp_sum, 8'h33);
        // Asynchronous reset while in EXEC drops the transaction.
        @(posedge clk);
        #1 do_req(1, 8'h33, 8'h44);
        #1 reset_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_valid", resp_valid, 0);
        check("async_pass", resp_pass, 0);
        check("async_sum", resp_sum, 0);
        check("async_id", resp_id, 0);
        sb.delete();
        mptr = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("async_no_resp", resp_valid, 0);
        end
        // Pointer back at 0: with 1 and 3 pending, 1 is first in search order.
        @(posedge clk);
        #1 set_ops(1, 8'h10, 8'h20);
        set_ops(3, 8'h40, 8'h50);
        valid = 4'b1010;
        wait_grant(4'b0010);
        wait_resp();
        @(posedge clk);
        #1 do_req(3, 8'hC0, 8'h40);
        wait_resp();
        // All requesters valid: grants rotate 0,1,2,3,0 every 3 cycles.
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) set_ops(k, W'(k * 16 + 1), W'(k + 2));
        valid = '1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            int n = 0;
            do @(negedge clk); while (ready == '0 && ++n < 20);
            idx = -1;
            for (int k = 0; k < N; k++) if (ready[k]) idx = k;
            check("rot_order", idx, g % N);
            if (g > 0) check("rot_interval", cyc - last, 3);
            last = cyc;
            @(posedge clk);
            if (g == 4) #1 valid = '0;
        end
        // Drain and confirm every expected response arrived.
        for (int n = 0; n < 30 && (sb.size() != 0 || busy); n++) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
